unsigned_approx_mult_pipe: RTL and testbench

UNSIGNED_APPROX_MULT_PIPE -- requirements
Module: unsigned_approx_mult_pipe

---
 rtl/unsigned_approx_mult_pipe.sv | 142 ++++++++++++++
 tb/tb_unsigned_approx_mult_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_approx_mult_pipe
// Description : Two-stage valid/ready unsigned multiplier; the low L partial
//               product rows are optionally OR-compressed above column K.
//               Also tracks a saturating sum of the approximation error.
// Revision    : 1.0 - initial release
// ============================================================================
module unsigned_approx_mult_pipe #(
    parameter int W     = 8,
    parameter int L     = 2,
    parameter int K     = W - 2,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     z,
    output logic [2*W-1:0]     err,
    input  logic               acc_clr,
    output logic [ACC_W-1:0]   err_acc,
    output logic               acc_sat
);

    localparam int c_HI_W  = 2*W - L;
    localparam int c_LO_W  = W + L;
    // Sum must hold both operands even when ACC_W is narrower than err.
    localparam int c_SUM_W = ((ACC_W > 2*W) ? ACC_W : 2*W) + 1;
    localparam logic [c_SUM_W-1:0] c_ACC_MAX = (c_SUM_W'(1) << ACC_W) - c_SUM_W'(1);

    logic                r_s1_valid;
    logic                r_s2_valid;
    logic [c_HI_W-1:0]   r_hi;
    logic [c_LO_W-1:0]   r_lo;
    logic [c_LO_W-1:0]   r_c;
    logic                r_approx;
    logic [2*W-1:0]      r_z;
    logic [2*W-1:0]      r_err;
    logic [ACC_W-1:0]    r_acc;
    logic                r_sat;

    logic [c_HI_W-1:0]   w_hi;
    logic [c_LO_W-1:0]   w_lo;
    logic [c_LO_W-1:0]   w_c;
    logic [2*W-1:0]      w_z_next;
    logic [2*W-1:0]      w_err_next;
    logic [c_SUM_W-1:0]  w_sum;
    logic                w_s2_load;
    logic                w_s1_adv;
    logic                w_in_fire;
    logic                w_out_fire;

    assign w_s2_load  = !r_s2_valid | out_ready;
    assign w_s1_adv   = r_s1_valid & w_s2_load;
    assign in_ready   = !r_s1_valid | w_s1_adv;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;

    assign w_hi = c_HI_W'(y) * c_HI_W'(x[W-1:L]);
    assign w_lo = c_LO_W'(y) * c_LO_W'(x[L-1:0]);

    // Each kept column of the low rows collapses to the OR of its bits.
    always_comb begin
        w_c = '0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < W; j++) begin
                if (i + j >= K) begin
                    w_c[i+j] = w_c[i+j] | (x[i] & y[j]);
                end
            end
        end
    end

    // OR-compression never exceeds the exact low-row sum, so r_lo - r_c >= 0.
    assign w_z_next   = {r_hi, {L{1'b0}}} + (2*W)'(r_approx ? r_c : r_lo);
    assign w_err_next = r_approx ? (2*W)'(r_lo - r_c) : '0;
    assign w_sum      = c_SUM_W'(r_acc) + c_SUM_W'(r_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_c        <= '0;
            r_approx   <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_hi       <= w_hi;
                r_lo       <= w_lo;
                r_c        <= w_c;
                r_approx   <= approx_en;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_err      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_z        <= w_z_next;
                r_err      <= w_err_next;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_out_fire) begin
            if (w_sum > c_ACC_MAX) begin
                r_acc <= c_ACC_MAX[ACC_W-1:0];
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign z         = r_z;
    assign err       = r_err;
    assign err_acc   = r_acc;
    assign acc_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_unsigned_approx_mult_pipe
// Description : Directed, table-driven bench for unsigned_approx_mult_pipe
//               (W=8, L=2, K=6) with a second ACC_W=12 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unsigned_approx_mult_pipe;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        en;
        logic [15:0] z;
        logic [15:0] err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic        approx_en = 1'b0;
    logic        out_ready = 1'b1;
    logic        acc_clr = 1'b0;

    logic        in_ready, out_valid, acc_sat;
    logic [15:0] z, err;
    logic [31:0] err_acc;
    logic        in_ready2, out_valid2, acc_sat2;
    logic [15:0] z2, err2;
    logic [11:0] err_acc2;

    int   checks = 0;
    int   errors = 0;
    bit   stall_seen;
    vec_t tbl [0:11];

    always #5 clk = ~clk;

    unsigned_approx_mult_pipe #(.W(8), .L(2), .K(6), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .err(err), .acc_clr(acc_clr),
        .err_acc(err_acc), .acc_sat(acc_sat)
    );

    unsigned_approx_mult_pipe #(.W(8), .L(2), .K(6), .ACC_W(12)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid2),
        .out_ready(out_ready), .z(z2), .err(err2), .acc_clr(acc_clr),
        .err_acc(err_acc2), .acc_sat(acc_sat2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
    endtask

    // Streams n table beats (or tbl[first] n times when rep); optional
    // backpressure holds out_ready low for cycles 3..5.
    task automatic run_stream(input int first, input int n, input bit bp, input bit rep);
        int ni, no, cyc, k;
        int in_cyc [0:63];
        ni = 0; no = 0; cyc = 0;
        stall_seen = 1'b0;
        while (no < n && cyc < 300) begin
            if (ni < n) begin
                k = rep ? first : first + ni;
                x = tbl[k].x; y = tbl[k].y; approx_en = tbl[k].en;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(bp && cyc >= 3 && cyc < 6);
            @(negedge clk);
            if (in_valid && !in_ready) stall_seen = 1'b1;
            if (out_valid) begin
                k = rep ? first : first + no;
                chk("z", z, tbl[k].z);
                chk("err", err, tbl[k].err);
                if (out_ready) begin
                    if (!bp) chk("latency", cyc - in_cyc[no], 2);
                    no++;
                end
            end
            if (in_valid && in_ready) begin
                in_cyc[ni] = cyc;
                ni++;
            end
            tick();
            cyc++;
        end
        if (no < n) chk("stream_timeout", no, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit seen;
        tbl[0]  = '{x:8'd255, y:8'd255, en:1'b1, z:16'd64708, err:16'd317};
        tbl[1]  = '{x:8'd255, y:8'd255, en:1'b0, z:16'd65025, err:16'd0};
        tbl[2]  = '{x:8'd3,   y:8'd48,  en:1'b1, z:16'd64,    err:16'd80};
        tbl[3]  = '{x:8'd3,   y:8'd64,  en:1'b1, z:16'd192,   err:16'd0};
        tbl[4]  = '{x:8'd0,   y:8'd0,   en:1'b1, z:16'd0,     err:16'd0};
        tbl[5]  = '{x:8'd4,   y:8'd5,   en:1'b1, z:16'd20,    err:16'd0};
        tbl[6]  = '{x:8'd1,   y:8'd255, en:1'b1, z:16'd192,   err:16'd63};
        tbl[7]  = '{x:8'd2,   y:8'd255, en:1'b1, z:16'd448,   err:16'd62};
        tbl[8]  = '{x:8'd200, y:8'd100, en:1'b0, z:16'd20000, err:16'd0};
        tbl[9]  = '{x:8'd7,   y:8'd3,   en:1'b1, z:16'd12,    err:16'd9};
        tbl[10] = '{x:8'd255, y:8'd1,   en:1'b1, z:16'd252,   err:16'd3};
        tbl[11] = '{x:8'd129, y:8'd192, en:1'b1, z:16'd24768, err:16'd0};

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_z", z, 0);
        chk("rst_err", err, 0);
        chk("rst_err_acc", err_acc, 0);
        chk("rst_acc_sat", acc_sat, 0);

        // Back-to-back table, no backpressure.
        run_stream(0, 12, 1'b0, 1'b0);
        chk("acc_after_table", err_acc, 534);
        chk("acc12_after_table", err_acc2, 534);

        pulse_clr();
        chk("acc_clr", err_acc, 0);
        run_stream(2, 2, 1'b0, 1'b0);
        chk("acc_80", err_acc, 80);

        // Clear coincident with an err=317 transfer wins over accumulation.
        x = 8'd255; y = 8'd255; approx_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("clr_beat_seen", seen, 1);
        chk("clr_beat_err", err, 317);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_priority_acc", err_acc, 0);
        chk("clr_beat_consumed", out_valid, 0);
        run_stream(0, 1, 1'b0, 1'b0);
        chk("acc_after_clr", err_acc, 317);

        // Backpressure mid-stream.
        run_stream(0, 8, 1'b1, 1'b0);
        chk("bp_in_ready_dropped", stall_seen, 1);
        chk("acc_after_bp", err_acc, 839);

        // Saturation on the 12-bit accumulator.
        pulse_clr();
        run_stream(0, 12, 1'b0, 1'b1);
        chk("acc12_3804", err_acc2, 3804);
        chk("sat12_clear", acc_sat2, 0);
        run_stream(0, 1, 1'b0, 1'b1);
        chk("acc12_saturated", err_acc2, 4095);
        chk("sat12_set", acc_sat2, 1);
        chk("acc32_4121", err_acc, 4121);
        run_stream(1, 1, 1'b0, 1'b1);
        chk("sat12_sticky_exact", acc_sat2, 1);
        run_stream(0, 1, 1'b0, 1'b1);
        chk("acc12_held", err_acc2, 4095);
        chk("sat12_sticky", acc_sat2, 1);
        chk("acc32_4438", err_acc, 4438);
        chk("sat32_clear", acc_sat, 0);

        // Reset with a beat sitting in stage 1 must discard it.
        x = 8'd255; y = 8'd255; approx_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_acc12", err_acc2, 0);
        chk("rst2_sat12", acc_sat2, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst2_no_ghost_beat", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
